// File: rtl/fft4_pkg.sv
// fft4_pkg: shared constants and types for the 4-point FFT controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default sample width, half width, Q1.15 twiddles W0/W1,
// packed complex sample type, controller state enum, slot bit-reverse helper.
package fft4_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int HALF      = WIDTH_DEF / 2;

  // Twiddles packed {re[31:16], im[15:0]} in Q1.15.
  // W0 = (32767, 0); W1 = (0, -32767), where -32767 = 16'h8001.
  localparam logic [31:0] W0 = 32'h7FFF_0000;
  localparam logic [31:0] W1 = 32'h0000_8001;

  typedef struct packed {
    logic signed [HALF-1:0] re;
    logic signed [HALF-1:0] im;
  } cplx_t;

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    S1_0   = 3'd1,
    S1_1   = 3'd2,
    S2_0   = 3'd3,
    S2_1   = 3'd4,
    UNLOAD = 3'd5
  } state_t;

  // The in-place radix-2 schedule leaves bin k in slot bitrev(k).
  function automatic logic [1:0] bitrev2(input logic [1:0] v);
    return {v[0], v[1]};
  endfunction

endpackage

// File: rtl/butterfly.sv
// butterfly: radix-2 complex butterfly, out0 = A + W*B, out1 = A - W*B.
// Latency: combinational, zero cycles.
// Backpressure: none (pure function of its inputs).
// Ports: a, b   complex samples {re[WIDTH-1:WIDTH/2], im[WIDTH/2-1:0]}, signed halves
//        w      Q1.15 twiddle {re[31:16], im[15:0]}
//        out0/1 results, each half wrapped to WIDTH/2 bits
// W*B is rounded half-up at the Q1.15 binary point before the add/subtract.
module butterfly #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [31:0]      w,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1
);

  localparam int H  = WIDTH / 2;
  localparam int PW = H + 17;  // holds a full H x 16 product sum without overflow
  localparam logic signed [PW-1:0] RND = PW'(16384);

  logic signed [PW-1:0] br, bi, wr, wi, pr, pi;
  logic [H-1:0] ar, ai, mr, mi;

  assign ar = a[WIDTH-1:H];
  assign ai = a[H-1:0];

  always_comb begin
    br = PW'($signed(b[WIDTH-1:H]));
    bi = PW'($signed(b[H-1:0]));
    wr = PW'($signed(w[31:16]));
    wi = PW'($signed(w[15:0]));
    pr = br * wr - bi * wi + RND;
    pi = br * wi + bi * wr + RND;
    mr = H'(pr >>> 15);
    mi = H'(pi >>> 15);
  end

  assign out0 = {ar + mr, ai + mi};
  assign out1 = {ar - mr, ai - mi};

endmodule

// File: rtl/fft4_ctrl.sv
// fft4_ctrl: 4-point complex FFT controller around a single shared butterfly.
// Latency: out_valid rises 5 clk edges after the edge accepting x[3]
//          (4 butterfly cycles, then one UNLOAD settling cycle).
// Backpressure: in_ready only in LOAD; UNLOAD holds each bin until out_ready.
// Ports: clk, rst (async active-high); in_valid/in_ready/in_data sample input;
//        out_valid/out_ready/out_data result output with out_index (bin k) and
//        out_last (k==3); busy high whenever not in LOAD.
// Option: define FFT4_STAGE_SCALE_EN to halve both butterfly outputs per stage.
module fft4_ctrl
  import fft4_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_index,
  output logic             out_last,
  output logic             busy
);

`ifdef FFT4_STAGE_SCALE_EN
  localparam int H = WIDTH / 2;
`endif

  state_t           state, state_nx;
  logic [1:0]       cnt;      // load slot in LOAD, bin index in UNLOAD
  logic             primed;   // first UNLOAD cycle is a settling cycle
  logic [WIDTH-1:0] mem [4];

  logic [1:0]       ia, ib;
  logic [31:0]      tw;
  logic             bf_en;
  logic [WIDTH-1:0] bf_out0, bf_out1;
  logic             in_fire, out_fire;

  function automatic logic [WIDTH-1:0] post_bf(input logic [WIDTH-1:0] v);
`ifdef FFT4_STAGE_SCALE_EN
    return {v[WIDTH-1], v[WIDTH-1:H+1], v[H-1], v[H-1:1]};
`else
    return v;
`endif
  endfunction

  // In-place schedule:
  //   S1_0 (x0,x2) -> s0@0, s1@2   S1_1 (x1,x3) -> s2@1, s3@3
  //   S2_0 (s0,s2) -> X0@0, X2@1   S2_1 (s1,s3,W1) -> X1@2, X3@3
  always_comb begin
    ia    = 2'd0;
    ib    = 2'd2;
    tw    = W0;
    bf_en = 1'b0;
    unique case (state)
      S1_0: begin ia = 2'd0; ib = 2'd2; bf_en = 1'b1; end
      S1_1: begin ia = 2'd1; ib = 2'd3; bf_en = 1'b1; end
      S2_0: begin ia = 2'd0; ib = 2'd1; bf_en = 1'b1; end
      S2_1: begin ia = 2'd2; ib = 2'd3; tw = W1; bf_en = 1'b1; end
      default: ;
    endcase
  end

  butterfly #(.WIDTH(WIDTH)) u_bf (
    .a    (mem[ia]),
    .b    (mem[ib]),
    .w    (tw),
    .out0 (bf_out0),
    .out1 (bf_out1)
  );

  assign in_ready  = (state == LOAD);
  assign busy      = (state != LOAD);
  assign out_valid = (state == UNLOAD) && primed;
  assign out_index = (state == UNLOAD) ? cnt : 2'd0;
  assign out_data  = out_valid ? mem[bitrev2(cnt)] : '0;
  assign out_last  = out_valid && (cnt == 2'd3);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    state_nx = state;
    unique case (state)
      LOAD:    if (in_fire && cnt == 2'd3) state_nx = S1_0;
      S1_0:    state_nx = S1_1;
      S1_1:    state_nx = S2_0;
      S2_0:    state_nx = S2_1;
      S2_1:    state_nx = UNLOAD;
      UNLOAD:  if (out_fire && cnt == 2'd3) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= LOAD;
      cnt    <= 2'd0;
      primed <= 1'b0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      state  <= state_nx;
      primed <= (state == UNLOAD) && !(out_fire && cnt == 2'd3);
      if (in_fire) begin
        mem[cnt] <= in_data;
        cnt      <= cnt + 2'd1;  // wraps to 0 after x[3]
      end
      if (out_fire) cnt <= cnt + 2'd1;  // wraps to 0 after X[3]
      if (bf_en) begin
        mem[ia] <= post_bf(bf_out0);
        mem[ib] <= post_bf(bf_out1);
      end
    end
  end

endmodule

// File: tb/tb_fft4_ctrl.sv
module tb_fft4_ctrl;
  import fft4_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [1:0]  out_index;
  logic        out_last;
  logic        busy;

  fft4_ctrl #(.WIDTH(WIDTH_DEF)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] frame_x [4];
  logic [31:0] exp_X   [4];

  typedef struct packed {
    logic [3:0][31:0] x;   // element [n] is x[n]
    logic [3:0][31:0] X;   // element [k] is X[k]
  } vec_t;

  vec_t  tbl [4];
  string tbl_name [4];

  function automatic logic [31:0] cp(input int re, input int im);
    logic [31:0] r, i;
    r = re;
    i = im;
    return {r[15:0], i[15:0]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ":in_ready"},  32'(in_ready),  32'd1);
    check({tag, ":out_valid"}, 32'(out_valid), 32'd0);
    check({tag, ":out_last"},  32'(out_last),  32'd0);
    check({tag, ":out_index"}, 32'(out_index), 32'd0);
    check({tag, ":out_data"},  out_data,       32'd0);
    check({tag, ":busy"},      32'(busy),      32'd0);
  endtask

  // Reference: plain 4-point DFT with exact twiddles {1,-j,-1,j}. Inputs used
  // here keep every intermediate within +-16384, where Q1.15 rounding is exact.
  task automatic model();
    int xr [4];
    int xi [4];
    for (int n = 0; n < 4; n++) begin
      xr[n] = int'($signed(frame_x[n][31:16]));
      xi[n] = int'($signed(frame_x[n][15:0]));
    end
`ifndef FFT4_STAGE_SCALE_EN
    for (int k = 0; k < 4; k++) begin
      int sr, si;
      sr = 0; si = 0;
      for (int n = 0; n < 4; n++) begin
        case ((n * k) % 4)
          0: begin sr += xr[n]; si += xi[n]; end
          1: begin sr += xi[n]; si -= xr[n]; end
          2: begin sr -= xr[n]; si -= xi[n]; end
          default: begin sr -= xi[n]; si += xr[n]; end
        endcase
      end
      exp_X[k] = cp(sr, si);
    end
`else
    begin
      int s0r, s0i, s1r, s1i, s2r, s2i, s3r, s3i, tr, ti;
      s0r = (xr[0] + xr[2]) >>> 1; s0i = (xi[0] + xi[2]) >>> 1;
      s1r = (xr[0] - xr[2]) >>> 1; s1i = (xi[0] - xi[2]) >>> 1;
      s2r = (xr[1] + xr[3]) >>> 1; s2i = (xi[1] + xi[3]) >>> 1;
      s3r = (xr[1] - xr[3]) >>> 1; s3i = (xi[1] - xi[3]) >>> 1;
      tr = s3i; ti = -s3r;  // -j * s3
      exp_X[0] = cp((s0r + s2r) >>> 1, (s0i + s2i) >>> 1);
      exp_X[2] = cp((s0r - s2r) >>> 1, (s0i - s2i) >>> 1);
      exp_X[1] = cp((s1r + tr) >>> 1, (s1i + ti) >>> 1);
      exp_X[3] = cp((s1r - tr) >>> 1, (s1i - ti) >>> 1);
    end
`endif
  endtask

  // Caller is away from a clock edge. Returns #1 after the edge accepting x[3].
  task automatic load_frame(input bit keep_valid);
    for (int n = 0; n < 4; n++) begin
      int g;
      g = 0;
      in_valid = 1'b1;
      in_data  = frame_x[n];
      while (!in_ready) begin
        @(posedge clk); #1;
        g++;
        if (g > 40) begin
          timeout_fail("load_in_ready");
          in_valid = 1'b0;
          return;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = keep_valid;
    in_data  = keep_valid ? 32'hDEAD_BEEF : 32'h0;
  endtask

  // Drains bins k=0..3. stall_k gets 3 ready-low cycles; rand_bp adds random
  // stalls elsewhere; stop_k >= 0 returns (at a negedge) once bin stop_k is shown.
  task automatic unload_frame(input string tag, input int stall_k, input bit rand_bp, input int stop_k);
    for (int k = 0; k < 4; k++) begin
      int g, stalls;
      g = 0;
      while (1) begin
        @(negedge clk);
        if (out_valid) break;
        g++;
        if (g > 30) begin
          timeout_fail({tag, ":out_valid"});
          return;
        end
      end
      stalls = (k == stall_k) ? 3 : (rand_bp ? int'($urandom_range(2, 0)) : 0);
      for (int s = 0; s < stalls; s++) begin
        out_ready = 1'b0;
        @(posedge clk); @(negedge clk);
        check({tag, ":hold_valid"}, 32'(out_valid), 32'd1);
        check({tag, ":hold_index"}, 32'(out_index), 32'(k));
        check({tag, ":hold_data"},  out_data,       exp_X[k]);
      end
      out_ready = 1'b1;
      check({tag, ":index"},    32'(out_index), 32'(k));
      check({tag, ":data"},     out_data,       exp_X[k]);
      check({tag, ":last"},     32'(out_last),  32'(k == 3));
      check({tag, ":in_ready"}, 32'(in_ready),  32'd0);
      if (k == stop_k) return;
      @(posedge clk);
    end
    @(negedge clk);
    check({tag, ":done_valid"}, 32'(out_valid), 32'd0);
  endtask

  task automatic use_vec(input int i);
    for (int n = 0; n < 4; n++) begin
      frame_x[n] = tbl[i].x[n];
      exp_X[n]   = tbl[i].X[n];
    end
  endtask

  initial begin
    int lat;

    // Concatenations list index 3 first: {x3, x2, x1, x0}.
    tbl_name[0] = "impulse";
    tbl[0].x = {cp(0, 0), cp(0, 0), cp(0, 0), cp(100, 0)};
    tbl_name[1] = "dc";
    tbl[1].x = {cp(100, 0), cp(100, 0), cp(100, 0), cp(100, 0)};
    tbl_name[2] = "shift";
    tbl[2].x = {cp(0, 0), cp(0, 0), cp(100, 0), cp(0, 0)};
    tbl_name[3] = "cplx";
    tbl[3].x = {cp(7, 8), cp(5, 6), cp(3, 4), cp(1, 2)};
`ifndef FFT4_STAGE_SCALE_EN
    tbl[0].X = {cp(100, 0), cp(100, 0), cp(100, 0), cp(100, 0)};
    tbl[1].X = {cp(0, 0), cp(0, 0), cp(0, 0), cp(400, 0)};
    tbl[2].X = {cp(0, 100), cp(-100, 0), cp(0, -100), cp(100, 0)};
    tbl[3].X = {cp(0, -8), cp(-4, -4), cp(-8, 0), cp(16, 20)};
`else
    tbl[0].X = {cp(25, 0), cp(25, 0), cp(25, 0), cp(25, 0)};
    tbl[1].X = {cp(0, 0), cp(0, 0), cp(0, 0), cp(100, 0)};
    tbl[2].X = {cp(0, 25), cp(-25, 0), cp(0, -25), cp(25, 0)};
    tbl[3].X = {cp(0, -2), cp(-1, -1), cp(-2, 0), cp(4, 5)};
`endif

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 4; i++) begin
      use_vec(i);
      load_frame(1'b0);
      unload_frame(tbl_name[i], -1, 1'b0, -1);
    end

    // Latency and k=1 backpressure on the shifted impulse.
    use_vec(2);
    load_frame(1'b0);
    lat = -1;
    for (int e = 1; e <= 20; e++) begin
      @(posedge clk); #1;
      if (e == 1) begin
        check("compute_busy",     32'(busy),     32'd1);
        check("compute_in_ready", 32'(in_ready), 32'd0);
      end
      if (out_valid) begin
        lat = e;
        break;
      end
    end
    check("latency", 32'(lat), 32'd5);
    unload_frame("bp", 1, 1'b0, -1);

    // Reset in S2_0: accept edge E, then E+1 -> S1_1, E+2 -> S2_0.
    use_vec(3);
    load_frame(1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_s2_0");
    @(negedge clk);
    rst = 1'b0;

    // Reset while bin k=2 is presented.
    use_vec(3);
    load_frame(1'b0);
    unload_frame("pre_rst", -1, 1'b0, 2);
    #1;
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_unload");
    @(negedge clk);
    rst = 1'b0;
    use_vec(1);
    load_frame(1'b0);
    unload_frame("after_rst", -1, 1'b0, -1);

    // Back-to-back with in_valid held high throughout.
    use_vec(3);
    load_frame(1'b1);
    for (int e = 0; e < 5; e++) begin
      check("b2b_in_ready_low", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    unload_frame("b2b_a", -1, 1'b0, -1);
    use_vec(2);
    load_frame(1'b0);
    unload_frame("b2b_b", -1, 1'b0, -1);

    // Randomized frames with random output stalls.
    for (int f = 0; f < 8; f++) begin
      for (int n = 0; n < 4; n++)
        frame_x[n] = cp(int'($urandom_range(8192, 0)) - 4096, int'($urandom_range(8192, 0)) - 4096);
      model();
      load_frame(1'b0);
      unload_frame("rand", -1, 1'b1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
